// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared FSM states and digit constants for the BCD-to-binary converter
package bcd2bin_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int DIGIT_W = 4;
    localparam int ADJ_THRESH = 8;
    localparam int ADJ_CORR = 3;
    localparam int DIGIT_MAX = 9;
endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: valid/ready handshake bundle between a BCD source/result sink and the converter
interface bcd_to_bin_seq_if import bcd2bin_pkg::*; #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_W = 10
);
    logic in_valid;
    logic in_ready;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in;
    logic out_valid;
    logic out_ready;
    logic [BIN_W-1:0] bin_out;
    logic busy;
    logic bcd_err;
    modport master (output in_valid, bcd_in, out_ready, input in_ready, out_valid, bin_out, busy, bcd_err);
    modport slave (input in_valid, bcd_in, out_ready, output in_ready, out_valid, bin_out, busy, bcd_err);
endinterface

// File: rtl/bcd_to_bin_seq_digit_adj.sv
// bcd_digit_adj: reverse double-dabble digit correction, subtract 3 from any digit of 8 or more
module bcd_digit_adj import bcd2bin_pkg::*; (
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q
);
    assign q = (d >= DIGIT_W'(ADJ_THRESH)) ? d - DIGIT_W'(ADJ_CORR) : d;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential BCD-to-binary converter, one shift per clock; BCD2BIN_DIGIT_CHECK_EN adds digit validation
module bcd_to_bin_seq import bcd2bin_pkg::*; #(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_W = 10
) (
    input logic clk,
    input logic rst_n,
    bcd_to_bin_seq_if.slave bus
);
    localparam int BCD_W = DIGIT_W * NUM_DIGITS;
    localparam int SR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    state_t state, state_nx;
    logic [SR_W-1:0] sr, sr_sh, sr_adj;
    logic [CNT_W-1:0] cnt;
    logic [BIN_W-1:0] bin_q;
    logic accept, last, err_q;
    assign sr_sh = sr >> 1;
    assign sr_adj[BIN_W-1:0] = sr_sh[BIN_W-1:0];
    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d(sr_sh[BIN_W + g*DIGIT_W +: DIGIT_W]),
                .q(sr_adj[BIN_W + g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate
    assign accept = bus.in_valid && state == IDLE;
    assign last = cnt == CNT_W'(BIN_W - 1);
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.busy = state == SHIFT;
        bus.out_valid = state == DONE;
        state_nx = accept ? SHIFT :
                   (state == SHIFT && last) ? DONE :
                   (state == DONE && bus.out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            bin_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sr <= {bus.bcd_in, {BIN_W{1'b0}}};
                cnt <= '0;
            end else if (state == SHIFT) begin
                sr <= sr_adj;
                cnt <= cnt + 1'b1;
                if (last) bin_q <= err_q ? '1 : sr_adj[BIN_W-1:0];
            end
        end
    end
    assign bus.bin_out = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic err_in;
    always_comb begin
        err_in = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            err_in = err_in | (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if (accept) err_q <= err_in;
    end
`else
    assign err_q = 1'b0;
`endif
    assign bus.bcd_err = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: scoreboard bench for bcd_to_bin_seq; directed vectors plus full legal sweep
module tb_bcd_to_bin_seq;
    typedef struct packed {logic [9:0] b; logic e;} exp_t;
    logic clk = 0;
    logic rst_n = 0;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 0;
    bit lat_on = 0;
    exp_t q[$];
    bcd_to_bin_seq_if #(.NUM_DIGITS(3), .BIN_W(10)) bus();
    bcd_to_bin_seq #(.NUM_DIGITS(3), .BIN_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("unexpected_output", 32'(bus.bin_out), 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("bin_out", 32'(bus.bin_out), 32'(e.b));
                chk("bcd_err", 32'(bus.bcd_err), 32'(e.e));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) lat_on <= 0;
        else if (bus.in_valid && bus.in_ready) begin
            lat <= 1;
            lat_on <= 1;
        end else if (lat_on) begin
            if (bus.out_valid) begin
                chk("latency", 32'(lat), 32'd11);
                lat_on <= 0;
            end else lat <= lat + 1;
        end
    end

    task automatic send(input logic [11:0] b, input logic [9:0] e, input logic er);
        int t = 0;
        bus.bcd_in = b;
        bus.in_valid = 1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
        else q.push_back('{b: e, e: er});
        @(negedge clk);
        bus.in_valid = 0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("out_valid_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int t;
        bus.in_valid = 0;
        bus.bcd_in = '0;
        bus.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bin_out", 32'(bus.bin_out), 32'd0);
        chk("rst_bcd_err", 32'(bus.bcd_err), 32'd0);
        rst_n = 1;
        @(negedge clk);
        send(12'h128, 10'd128, 0);
        chk("shift_in_ready", 32'(bus.in_ready), 32'd0);
        chk("shift_busy", 32'(bus.busy), 32'd1);
        wait_out();
        @(negedge clk);
        send(12'h999, 10'd999, 0);
        send(12'h000, 10'd0, 0);
        send(12'h001, 10'd1, 0);
        wait_out();
        @(negedge clk);
        bus.out_ready = 0;
        send(12'h255, 10'd255, 0);
        wait_out();
        bus.bcd_in = 12'h777;
        bus.in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_bin_out", 32'(bus.bin_out), 32'd255);
            chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1;
        send(12'h777, 10'd777, 0);
        wait_out();
        @(negedge clk);
        send(12'h500, 10'd500, 0);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 0;
        #1;
        q.delete();
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_bin_out", 32'(bus.bin_out), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        send(12'h042, 10'd42, 0);
        wait_out();
        @(negedge clk);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        send(12'h1A3, 10'h3FF, 1);
        send(12'h123, 10'd123, 0);
        wait_out();
        @(negedge clk);
`endif
        prev = -1;
        for (int i = 0; i < 1000; i++) begin
            send({4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)}, 10'(i), 0);
            if (prev >= 0) chk("word_period", 32'(cyc - prev), 32'd12);
            prev = cyc;
        end
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
